counter_display_multi: RTL and testbench
========================================

# counter_display_multi

Parametrised successor to the single-digit increment/display unit: a DIGITS-wide up/down counter in hexadecimal or decimal, driven by three debounced push-buttons with hold-to-repeat. It drives one seven-segment digit per counter digit. It sits between the board switches and the segment pins and is the standard front-panel counter for later projects. Debounce, edge detection, the repeat state machine, the digit arithmetic and segment decode all live inside the block.

## Interface
- DIGITS, 2, number of counter and display digits (1..4)
- RADIX, 16, per-digit modulus; only 10 or 16 are legal
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a switch change (10 ms at 25 MHz)
- REPEAT_DELAY, 12500000, cycles a direction button is held before auto-repeat starts; 0 disables repeat
- REPEAT_RATE, 2500000, cycles between auto-repeat steps (must be ≥1)
- ACTIVE_LOW_SEG, 1, 1 means segment outputs are driven low to light

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Switch_Up  in  1  raw increment button, active high
- i_Switch_Down  in  1  raw decrement button, active high
- i_Switch_Reset  in  1  raw clear button, active high
- o_Count  out  4*DIGITS  counter value; digit k occupies bits [4k+3:4k], digit 0 is least significant
- o_Segments  out  7*DIGITS  digit k occupies bits [7k+6:7k], ordered A..G from MSB to LSB
- o_Wrap  out  1  one-cycle pulse when the count wraps (max→0 or 0→max)

## Operation
- **Input synchronisation:** each raw switch passes through a 2-flop synchroniser, then its own debouncer.
- **Debouncer:** a counter increments while the synced input differs from the debounced state and clears whenever they match. When it reaches DEBOUNCE_LIMIT-1, the debounced state flips and the counter clears.
- **Edge detection:** a registered copy of each debounced level gives one-cycle rise flags.
- **Priority:** reset rise > up rise > down rise.
  - If the up and down debounced levels are both high, no step occurs and the FSM returns to IDLE.
  - While reset is held high, all stepping is inhibited.
- **Repeat FSM states:**
  - IDLE:
    - up rise with down low → step +1, load timer with REPEAT_DELAY-1, go to HOLD(dir=up).
    - down rise with up low → step -1, go to HOLD(dir=down).
    - If REPEAT_DELAY=0, stay in IDLE after the step.
  - HOLD:
    - active button released, or other button pressed → IDLE.
    - timer reaches 0 → step, load REPEAT_RATE-1, go to REPEAT.
  - REPEAT:
    - timer reaches 0 → step, reload REPEAT_RATE-1.
    - release or other button pressed → IDLE.
  - Reset rise, from any state → IDLE.
- **Arithmetic:**
  - Each digit counts modulo RADIX, with a ripple carry on increment and a ripple borrow on decrement.
  - Full count RADIX^DIGITS-1 incremented → all zeros, with o_Wrap pulsed.
  - All zeros decremented → every digit at RADIX-1, with o_Wrap pulsed.
  - The reset-button clear does not pulse o_Wrap.
- **Segment decode:**
  - Standard hex glyphs 0-9 and A,b,C,d,E,F; A..G are all active-high before polarity.
  - Outputs are inverted when ACTIVE_LOW_SEG=1.
  - In RADIX 10, digits never exceed 9.

## Timing
- **Async reset (i_Rst_n=0):**
  - o_Count=0 and o_Wrap=0.
  - Every digit of o_Segments shows "0": 7'b0000001 when ACTIVE_LOW_SEG=1, 7'b1111110 otherwise.
  - All debounced levels, timers and counters are cleared, and the FSM is in IDLE.
- **Release of i_Rst_n:** takes effect on the next rising edge of i_Clk.
- **Raw press to step:** 2 sync cycles + DEBOUNCE_LIMIT cycles + 1 edge-detect cycle + 1 register cycle. o_Count changes on that final edge.
- **o_Wrap:** asserted in the same cycle o_Count takes the wrapped value.
- **o_Segments:** registered; it follows o_Count by exactly 1 cycle.
- **First auto-repeat step:** exactly REPEAT_DELAY cycles after the press step. Later steps are spaced exactly REPEAT_RATE cycles apart.
- **Glitches:** any bounce shorter than DEBOUNCE_LIMIT cycles produces no step.
- **Reset mid-repeat:** the clear applies 1 cycle after the reset rise. No repeat step occurs until the reset button is released and a new direction press is made.

## Test plan
Bench parameters for all scenarios: DIGITS=2, DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_RATE=5.

- **Reset values:** assert i_Rst_n=0 mid-count → o_Count=0 immediately; o_Segments=14'b0000001_0000001; o_Wrap=0.
- **Bounce rejection:**
  - Toggle i_Switch_Up with 3-cycle pulses 10 times → o_Count stays 0.
  - Then hold it high for 10 cycles → o_Count=1 and exactly one step.
- **Decimal wrap up:**
  - RADIX=10, count preloaded to 98 by presses.
  - Press up → o_Count=0x99.
  - Press up again → o_Count=0x00 with a one-cycle o_Wrap.
  - Press down → o_Count=0x99 with o_Wrap pulsed again.
- **Hex carry and decode:** RADIX=16 at 0x0F, press up → o_Count=0x10; one cycle later digit1 shows "1" and digit0 shows "0".
- **Auto-repeat:** hold up for 2+4+1+20+5*3 cycles after the press → exactly 5 steps, spaced 20 then 5 cycles apart. Release → no further steps.
- **Simultaneous inputs:**
  - Up and down pressed in the same cycle → no step.
  - Reset pressed during REPEAT → o_Count=0, no o_Wrap, and no steps while reset is held.

Source files
------------

// File: rtl/counter_display_multi.sv
// Multi-digit hex/decimal up/down front-panel counter with debounced
// buttons, hold-to-repeat and registered seven-segment outputs.
module counter_display_multi #(
  parameter int DIGITS         = 2,
  parameter int RADIX          = 16,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Switch_Up,
  input  logic                  i_Switch_Down,
  input  logic                  i_Switch_Reset,
  output logic [4*DIGITS-1:0]   o_Count,
  output logic [7*DIGITS-1:0]   o_Segments,
  output logic                  o_Wrap
);

  localparam int DW =
    (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [DW-1:0] DB_MAX =
    DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [3:0] DMAX = 4'(RADIX - 1);
  localparam logic [31:0] DLY_LD =
    (REPEAT_DELAY > 0) ? 32'(REPEAT_DELAY - 1) : 32'd0;
  localparam logic [31:0] RATE_LD =
    (REPEAT_RATE > 0) ? 32'(REPEAT_RATE - 1) : 32'd0;
  localparam logic [6:0] SEG_POL =
    ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_ZERO =
    7'b1111110 ^ SEG_POL;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_e;

  // bit 0 = up, bit 1 = down, bit 2 = clear
  logic [2:0]    raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    db_q;
  logic [2:0]    prev_q;
  logic [2:0]    rise_q;
  logic [DW-1:0] dbc_q [3];

  state_e                state_q;
  logic                  dn_q;
  logic [31:0]           timer_q;
  logic [4*DIGITS-1:0]   count_q;
  logic                  wrap_q;
  logic [7*DIGITS-1:0]   seg_q;

  logic [4*DIGITS-1:0]   inc_d;
  logic [4*DIGITS-1:0]   dec_d;
  logic                  inc_wrap;
  logic                  dec_wrap;
  logic [7*DIGITS-1:0]   seg_d;
  logic                  act_lvl;
  logic                  oth_lvl;

  assign raw = {i_Switch_Reset, i_Switch_Down, i_Switch_Up};

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      for (int k = 0; k < 3; k++) begin
        dbc_q[k] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= db_q;
      rise_q  <= db_q & ~prev_q;
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] == db_q[k]) begin
          dbc_q[k] <= '0;
        end else if (dbc_q[k] == DB_MAX) begin
          db_q[k]  <= ~db_q[k];
          dbc_q[k] <= '0;
        end else begin
          dbc_q[k] <= dbc_q[k] + 1'b1;
        end
      end
    end
  end

  // Ripple carry / borrow through the digits, LSB first
  always_comb begin
    logic       cy;
    logic       bw;
    logic [3:0] dg;
    inc_d = count_q;
    dec_d = count_q;
    cy    = 1'b1;
    bw    = 1'b1;
    dg    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      dg = count_q[4*k +: 4];
      if (cy) begin
        if (dg == DMAX) begin
          inc_d[4*k +: 4] = 4'd0;
        end else begin
          inc_d[4*k +: 4] = dg + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (dg == 4'd0) begin
          dec_d[4*k +: 4] = DMAX;
        end else begin
          dec_d[4*k +: 4] = dg - 4'd1;
          bw = 1'b0;
        end
      end
    end
    inc_wrap = cy;
    dec_wrap = bw;
  end

  function automatic logic [6:0] glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      seg_d[7*k +: 7] = glyph(count_q[4*k +: 4]) ^ SEG_POL;
    end
  end

  assign act_lvl = dn_q ? db_q[1] : db_q[0];
  assign oth_lvl = dn_q ? db_q[0] : db_q[1];

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      dn_q    <= 1'b0;
      timer_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= {DIGITS{SEG_ZERO}};
    end else begin
      wrap_q <= 1'b0;
      seg_q  <= seg_d;
      if (rise_q[2]) begin
        count_q <= '0;
        state_q <= ST_IDLE;
      end else if (db_q[2]) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_q[0] && !db_q[1]) begin
              count_q <= inc_d;
              wrap_q  <= inc_wrap;
              dn_q    <= 1'b0;
              timer_q <= DLY_LD;
              state_q <= (REPEAT_DELAY == 0) ?
                         ST_IDLE : ST_HOLD;
            end else if (rise_q[1] && !db_q[0]) begin
              count_q <= dec_d;
              wrap_q  <= dec_wrap;
              dn_q    <= 1'b1;
              timer_q <= DLY_LD;
              state_q <= (REPEAT_DELAY == 0) ?
                         ST_IDLE : ST_HOLD;
            end
          end
          default: begin
            if (!act_lvl || oth_lvl) begin
              state_q <= ST_IDLE;
            end else if (timer_q == 32'd0) begin
              count_q <= dn_q ? dec_d : inc_d;
              wrap_q  <= dn_q ? dec_wrap : inc_wrap;
              timer_q <= RATE_LD;
              state_q <= ST_REPEAT;
            end else begin
              timer_q <= timer_q - 32'd1;
            end
          end
        endcase
      end
    end
  end

  assign o_Count    = count_q;
  assign o_Segments = seg_q;
  assign o_Wrap     = wrap_q;

endmodule

// File: tb/tb_counter_display_multi.sv
// Directed bench: one hex and one decimal counter, stepped
// cycle by cycle with hand-computed expectations.
module tb_counter_display_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up_h = 1'b0, dn_h = 1'b0, rs_h = 1'b0;
  logic up_d = 1'b0, dn_d = 1'b0, rs_d = 1'b0;
  logic [7:0]  cnt_h, cnt_d;
  logic [13:0] seg_h, seg_d;
  logic        wrap_h, wrap_d;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int steps_h[$];
  int wraps_h = 0;
  int wraps_d = 0;
  int wrap_ok_d = 0;
  logic [7:0] last_h = 8'h00;
  logic [7:0] last_d = 8'h00;

  always #5 clk = ~clk;

  counter_display_multi #(
    .DIGITS(2), .RADIX(16), .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY(20), .REPEAT_RATE(5),
    .ACTIVE_LOW_SEG(1'b1)
  ) u_hex (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Switch_Up(up_h), .i_Switch_Down(dn_h),
    .i_Switch_Reset(rs_h),
    .o_Count(cnt_h), .o_Segments(seg_h), .o_Wrap(wrap_h)
  );

  counter_display_multi #(
    .DIGITS(2), .RADIX(10), .DEBOUNCE_LIMIT(4),
    .REPEAT_DELAY(20), .REPEAT_RATE(5),
    .ACTIVE_LOW_SEG(1'b1)
  ) u_dec (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Switch_Up(up_d), .i_Switch_Down(dn_d),
    .i_Switch_Reset(rs_d),
    .o_Count(cnt_d), .o_Segments(seg_d), .o_Wrap(wrap_d)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cnt_h != last_h) begin
        steps_h.push_back(cyc);
        last_h = cnt_h;
      end
      if (wrap_h) wraps_h++;
      if (wrap_d) begin
        wraps_d++;
        if (cnt_d != last_d) wrap_ok_d++;
      end
      last_d = cnt_d;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      0: up_h = v;
      1: dn_h = v;
      2: rs_h = v;
      3: up_d = v;
      default: dn_d = v;
    endcase
  endtask

  task automatic press(input int which);
    drive(which, 1'b1);
    tick(10);
    drive(which, 1'b0);
    tick(12);
  endtask

  initial begin
    // power-on reset
    tick(2);
    chk("rst_count", cnt_h, 0);
    chk("rst_seg", seg_h, 14'b0000001_0000001);
    chk("rst_wrap", wrap_h, 0);
    rst_n = 1'b1;
    tick(3);

    // bounce rejection
    for (int i = 0; i < 10; i++) begin
      up_h = 1'b1; tick(3);
      up_h = 1'b0; tick(3);
    end
    tick(10);
    chk("bounce_count", cnt_h, 0);
    chk("bounce_steps", steps_h.size(), 0);

    c0 = cyc;
    up_h = 1'b1; tick(10);
    up_h = 1'b0; tick(15);
    chk("hold_count", cnt_h, 1);
    chk("hold_steps", steps_h.size(), 1);
    chk("press_latency", steps_h[0] - c0, 8);

    // hex carry and decode
    for (int i = 0; i < 14; i++) press(0);
    chk("hex_0F", cnt_h, 8'h0F);
    chk("seg_0F", seg_h, 14'b0000001_0111000);
    up_h = 1'b1;
    tick(7);
    chk("hex_pre_step", cnt_h, 8'h0F);
    tick(1);
    chk("hex_carry", cnt_h, 8'h10);
    chk("seg_lag", seg_h, 14'b0000001_0111000);
    tick(1);
    chk("seg_10", seg_h, 14'b1001111_0000001);
    up_h = 1'b0;
    tick(15);

    // auto-repeat: steps at +8, +28, +33, +38, +43
    steps_h.delete();
    c0 = cyc;
    up_h = 1'b1; tick(40);
    up_h = 1'b0; tick(30);
    chk("rep_steps", steps_h.size(), 5);
    chk("rep_count", cnt_h, 8'h15);
    chk("rep_first", steps_h[0] - c0, 8);
    chk("rep_delay", steps_h[1] - steps_h[0], 20);
    chk("rep_rate1", steps_h[2] - steps_h[1], 5);
    chk("rep_rate2", steps_h[3] - steps_h[2], 5);
    chk("rep_rate3", steps_h[4] - steps_h[3], 5);

    // up and down together
    steps_h.delete();
    up_h = 1'b1; dn_h = 1'b1; tick(30);
    up_h = 1'b0; dn_h = 1'b0; tick(20);
    chk("simul_steps", steps_h.size(), 0);
    chk("simul_count", cnt_h, 8'h15);

    // clear button while repeating
    wraps_h = 0;
    up_h = 1'b1; tick(35);
    rs_h = 1'b1; tick(7);
    chk("clr_before", cnt_h, 8'h19);
    tick(1);
    chk("clr_count", cnt_h, 0);
    chk("clr_wrap", wrap_h, 0);
    steps_h.delete();
    tick(30);
    chk("clr_held_steps", steps_h.size(), 0);
    chk("clr_wraps", wraps_h, 0);
    rs_h = 1'b0; tick(40);
    chk("clr_release_steps", steps_h.size(), 0);
    up_h = 1'b0; tick(15);
    press(0);
    chk("clr_new_press", cnt_h, 1);

    // decimal wrap
    for (int i = 0; i < 98; i++) press(3);
    chk("dec_98", cnt_d, 8'h98);
    chk("dec_nowrap", wraps_d, 0);
    press(3);
    chk("dec_99", cnt_d, 8'h99);
    press(3);
    chk("dec_wrap_up", cnt_d, 8'h00);
    chk("dec_wrap_up_n", wraps_d, 1);
    press(4);
    chk("dec_wrap_dn", cnt_d, 8'h99);
    chk("dec_wrap_dn_n", wraps_d, 2);
    chk("dec_wrap_align", wrap_ok_d, 2);

    // asynchronous reset mid-count
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count_h", cnt_h, 0);
    chk("async_count_d", cnt_d, 0);
    chk("async_seg", seg_h, 14'b0000001_0000001);
    chk("async_wrap", wrap_h, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
